instruction_fetch: RTL and testbench

Instruction-fetch stage that consumes the program counter from the PC register and fills the IF/ID pipeline register. Holds word-addressed instruction memory, with a program-load write port used while the core is idle. Presents the fetched instruction, `pc+4` and a valid flag to decode. Supports pipeline stall and branch flush.

---
 rtl/instruction_fetch_if.sv | 26 ++
 rtl/instruction_fetch.sv | 79 +++++++
 tb/tb_instruction_fetch.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Bus between the PC/program-load side and the instruction-fetch stage.
// master drives PC, control and write port; slave returns the IF/ID contents.
interface instruction_fetch_if;
    logic        enable;
    logic [31:0] pc_in;
    logic        stall;
    logic        flush;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [31:0] instruction_out;
    logic [31:0] pc_plus4_out;
    logic        valid_out;
    logic        misaligned_out;
    logic        halted;

    modport master (
        output enable, pc_in, stall, flush, wr_en, wr_addr, wr_data,
        input  instruction_out, pc_plus4_out, valid_out, misaligned_out, halted
    );

    modport slave (
        input  enable, pc_in, stall, flush, wr_en, wr_addr, wr_data,
        output instruction_out, pc_plus4_out, valid_out, misaligned_out, halted
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: word-addressed instruction memory plus the IF/ID register.
// Optional sticky halt detection is enabled by defining IFETCH_HALT_DETECT_EN.
module instruction_fetch #(
    parameter int unsigned ADDR_BITS = 8,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input logic               clk,
    input logic               reset,
    instruction_fetch_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [31:0]          mem [DEPTH];
    logic [ADDR_BITS-1:0] rd_index;
    logic [ADDR_BITS-1:0] wr_index;
    logic [31:0]          rd_word;
    logic                 capture;
    logic                 halted_q;
    logic [31:0]          instr_q;
    logic [31:0]          pc4_q;
    logic                 valid_q;
    logic                 mis_q;
    logic                 unused_bits;

    assign rd_index = bus.pc_in[ADDR_BITS+1:2];
    assign wr_index = bus.wr_addr[ADDR_BITS+1:2];
    assign rd_word  = mem[rd_index];
    assign capture  = bus.enable && !bus.flush && !bus.stall;

    assign unused_bits = ^{bus.pc_in[31:ADDR_BITS+2], bus.wr_addr[31:ADDR_BITS+2],
                           bus.wr_addr[1:0], HALT_WORD};

    // Write lands after the same-edge read samples rd_word, giving read-first.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem[wr_index] <= bus.wr_data;
        end
    end

`ifdef IFETCH_HALT_DETECT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halted_q <= 1'b0;
        end else if (capture && (rd_word == HALT_WORD)) begin
            halted_q <= 1'b1;
        end
    end
`else
    assign halted_q = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else if (bus.enable) begin
            // Once halted, every non-held capture becomes a bubble like a flush.
            if (bus.flush || (!bus.stall && halted_q)) begin
                instr_q <= '0;
                pc4_q   <= '0;
                valid_q <= 1'b0;
                mis_q   <= 1'b0;
            end else if (!bus.stall) begin
                instr_q <= rd_word;
                pc4_q   <= bus.pc_in + 32'd4;
                valid_q <= 1'b1;
                mis_q   <= (bus.pc_in[1:0] != 2'b00);
            end
        end
    end

    assign bus.instruction_out = instr_q;
    assign bus.pc_plus4_out    = pc4_q;
    assign bus.valid_out       = valid_q;
    assign bus.misaligned_out  = mis_q;
    assign bus.halted          = halted_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: vector table, scoreboard queue,
// and hand sequences for reset, same-edge write and halt behaviour.
module tb_instruction_fetch;
    localparam int unsigned ADDR_BITS = 8;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
        logic        halted;
    } exp_t;

    typedef struct {
        logic        en;
        logic [31:0] pc;
        logic        stall;
        logic        flush;
        logic        wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        exp_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    vec_t vecs[15];

    instruction_fetch_if bus();

    instruction_fetch #(
        .ADDR_BITS(ADDR_BITS),
        .HALT_WORD(HALT_WORD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc4,
                                input logic valid, input logic mis, input logic halted);
        exp_t e;
        e.instr  = instr;
        e.pc4    = pc4;
        e.valid  = valid;
        e.mis    = mis;
        e.halted = halted;
        return e;
    endfunction

    function automatic vec_t mv(input logic en, input logic [31:0] pc, input logic stall,
                                input logic flush, input logic wr, input logic [31:0] waddr,
                                input logic [31:0] wdata, input exp_t e);
        vec_t v;
        v.en    = en;
        v.pc    = pc;
        v.stall = stall;
        v.flush = flush;
        v.wr    = wr;
        v.waddr = waddr;
        v.wdata = wdata;
        v.exp   = e;
        return v;
    endfunction

    task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check_field({tag, ".instr"},  bus.instruction_out, e.instr);
        check_field({tag, ".pc4"},    bus.pc_plus4_out,    e.pc4);
        check_field({tag, ".valid"},  {31'd0, bus.valid_out},      {31'd0, e.valid});
        check_field({tag, ".mis"},    {31'd0, bus.misaligned_out}, {31'd0, e.mis});
        check_field({tag, ".halted"}, {31'd0, bus.halted},         {31'd0, e.halted});
    endtask

    task automatic pop_and_check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, got %h expected an entry", tag, bus.instruction_out);
        end else begin
            e = exp_q.pop_front();
            check_outputs(tag, e);
        end
    endtask

    task automatic apply(input string tag, input vec_t v);
        bus.enable  = v.en;
        bus.pc_in   = v.pc;
        bus.stall   = v.stall;
        bus.flush   = v.flush;
        bus.wr_en   = v.wr;
        bus.wr_addr = v.waddr;
        bus.wr_data = v.wdata;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        pop_and_check(tag);
    endtask

    task automatic fetch(input string tag, input logic [31:0] pc, input logic flush, input exp_t e);
        apply(tag, mv(1'b1, pc, 1'b0, flush, 1'b0, '0, '0, e));
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] data);
        bus.enable  = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic mid_cycle_reset(input string tag);
        fetch({tag, ".pre"}, 32'h0, 1'b0, mk(32'h2001_0005, 32'h4, 1'b1, 1'b0, 1'b0));
        #2;
        reset = 1'b0;
        #1;
        check_outputs({tag, ".async"}, mk('0, '0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        bus.enable  = 1'b0;
        bus.pc_in   = '0;
        bus.stall   = 1'b0;
        bus.flush   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;

        vecs[0]  = mv(1, 32'h0000_0000, 0, 0, 0, '0, '0, mk(32'h2001_0005, 32'h4, 1, 0, 0));
        vecs[1]  = mv(1, 32'h0000_0004, 0, 0, 0, '0, '0, mk(32'h2002_0007, 32'h8, 1, 0, 0));
        vecs[2]  = mv(1, 32'h0000_0008, 1, 0, 0, '0, '0, mk(32'h2002_0007, 32'h8, 1, 0, 0));
        vecs[3]  = mv(1, 32'h0000_0008, 1, 0, 0, '0, '0, mk(32'h2002_0007, 32'h8, 1, 0, 0));
        vecs[4]  = mv(1, 32'h0000_0008, 1, 0, 0, '0, '0, mk(32'h2002_0007, 32'h8, 1, 0, 0));
        vecs[5]  = mv(1, 32'h0000_0008, 0, 0, 0, '0, '0, mk(32'h3333_3333, 32'hC, 1, 0, 0));
        vecs[6]  = mv(1, 32'h0000_000C, 1, 1, 0, '0, '0, mk(32'h0, 32'h0, 0, 0, 0));
        vecs[7]  = mv(1, 32'h0000_0400, 0, 0, 0, '0, '0, mk(32'h2001_0005, 32'h404, 1, 0, 0));
        vecs[8]  = mv(1, 32'hFFFF_FFFC, 0, 0, 0, '0, '0, mk(32'hAAAA_5555, 32'h0, 1, 0, 0));
        vecs[9]  = mv(1, 32'h0000_0006, 0, 0, 0, '0, '0, mk(32'h2002_0007, 32'hA, 1, 1, 0));
        vecs[10] = mv(0, 32'h0000_0000, 0, 1, 0, '0, '0, mk(32'h2002_0007, 32'hA, 1, 1, 0));
        vecs[11] = mv(1, 32'h0000_0010, 0, 0, 1, 32'h12, 32'hDEAD_BEEF,
                      mk(32'h1111_1111, 32'h14, 1, 0, 0));
        vecs[12] = mv(1, 32'h0000_0010, 0, 0, 0, '0, '0, mk(32'hDEAD_BEEF, 32'h14, 1, 0, 0));
        vecs[13] = mv(1, 32'h0000_0010, 0, 1, 0, '0, '0, mk(32'h0, 32'h0, 0, 0, 0));
        vecs[14] = mv(1, 32'h0000_0005, 0, 0, 0, '0, '0, mk(32'h2002_0007, 32'h9, 1, 1, 0));

        #2;
        check_outputs("reset_state", mk('0, '0, 1'b0, 1'b0, 1'b0));

        // Program load while reset is held; memory has no reset.
        load(32'h0000_0000, 32'h2001_0005);
        load(32'h0000_0004, 32'h2002_0007);
        load(32'h0000_0008, 32'h3333_3333);
        load(32'h0000_0010, 32'h1111_1111);
        load(32'h0000_03FC, 32'hAAAA_5555);
        check_outputs("reset_hold", mk('0, '0, 1'b0, 1'b0, 1'b0));
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

`ifdef IFETCH_HALT_DETECT_EN
        load(32'h0000_000C, HALT_WORD);
        fetch("halt_flush", 32'hC, 1'b1, mk(32'h0, 32'h0, 0, 0, 0));
        fetch("halt_pc0",   32'h0, 1'b0, mk(32'h2001_0005, 32'h4, 1, 0, 0));
        fetch("halt_pc4",   32'h4, 1'b0, mk(32'h2002_0007, 32'h8, 1, 0, 0));
        fetch("halt_pc8",   32'h8, 1'b0, mk(32'h3333_3333, 32'hC, 1, 0, 0));
        fetch("halt_pcC",   32'hC, 1'b0, mk(HALT_WORD, 32'h10, 1, 0, 1));
        fetch("halt_pc10",  32'h10, 1'b0, mk(32'h0, 32'h0, 0, 0, 1));
        fetch("halt_pc14",  32'h14, 1'b0, mk(32'h0, 32'h0, 0, 0, 1));
        #2;
        reset = 1'b0;
        #1;
        check_outputs("halt_reset", mk('0, '0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        reset = 1'b1;
`else
        load(32'h0000_000C, HALT_WORD);
        fetch("nohalt_pcC",  32'hC,  1'b0, mk(HALT_WORD, 32'h10, 1, 0, 0));
        fetch("nohalt_pc10", 32'h10, 1'b0, mk(32'hDEAD_BEEF, 32'h14, 1, 0, 0));
`endif

        mid_cycle_reset("mid_reset");
        fetch("post_reset", 32'h4, 1'b0, mk(32'h2002_0007, 32'h8, 1, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
